// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - handshake bundle between the datapath control and seq_alu
//
// Purpose: groups the request (op/operands) and response (result/flags)
// handshakes of seq_alu.
// Signals:
//   in_valid, op[2:0], data1, data2  request side, qualified by in_ready
//   in_ready                         ALU can take a request this cycle
//   out_valid, alu_out, flags[3:0]   registered result and {Z,N,C,V}
//   out_ready                        consumer takes the result
//   busy                             multiply in progress
// Modports: master drives requests and out_ready; slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, op, data1, data2, out_ready,
    input  in_ready, out_valid, alu_out, flags, busy
  );

  modport slave (
    input  in_valid, op, data1, data2, out_ready,
    output in_ready, out_valid, alu_out, flags, busy
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with flags and iterative multiply
//
// Purpose: datapath ALU between register-file read and write-back.
// Ops: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SHL, 111 MUL.
// Single-cycle ops return their result the cycle after accept; MUL runs a
// shift-add loop of WIDTH cycles and returns WIDTH+1 cycles after accept.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      seq_alu_if.slave (in_valid/in_ready/op/data1/data2,
//            out_valid/out_ready/alu_out/flags, busy)
module seq_alu #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      reset_n,
  seq_alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [SW-1:0] LAST_ITER = SW'(WIDTH - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   res_q;
  logic [3:0]         flags_q;
  logic [SW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_n;

  logic               accept;
  logic               is_mul;

  logic [WIDTH-1:0]   r_c;
  logic               c_c;
  logic               v_c;
  logic [WIDTH:0]     sum_x;
  logic [WIDTH:0]     dif_x;
  logic [WIDTH:0]     shl_x;

  assign bus.in_ready  = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state == S_MUL);
  assign bus.alu_out   = res_q;
  assign bus.flags     = flags_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign is_mul = MUL_EN && (bus.op == OP_MUL);

  // One extra bit on the left captures carry/borrow, and for SHL it holds the
  // last bit pushed out (zero when the shift amount is zero).
  assign sum_x = {1'b0, bus.data1} + {1'b0, bus.data2};
  assign dif_x = {1'b0, bus.data1} - {1'b0, bus.data2};
  assign shl_x = {1'b0, bus.data1} << bus.data2[SW-1:0];

  always_comb begin
    r_c = '0;
    c_c = 1'b0;
    v_c = 1'b0;
    case (bus.op)
      OP_NOP: r_c = '0;
      OP_ADD: begin
        r_c = sum_x[WIDTH-1:0];
        c_c = sum_x[WIDTH];
        v_c = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
              (sum_x[WIDTH-1] != bus.data1[WIDTH-1]);
      end
      OP_SUB: begin
        r_c = dif_x[WIDTH-1:0];
        c_c = ~dif_x[WIDTH];
        v_c = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
              (dif_x[WIDTH-1] != bus.data1[WIDTH-1]);
      end
      OP_AND: r_c = bus.data1 & bus.data2;
      OP_OR:  r_c = bus.data1 | bus.data2;
      OP_XOR: r_c = bus.data1 ^ bus.data2;
      OP_SHL: begin
        r_c = shl_x[WIDTH-1:0];
        c_c = shl_x[WIDTH];
      end
      OP_MUL: r_c = '0;
    endcase
  end

  // One partial product per cycle: multiplicand walks left, multiplier right.
  assign acc_n = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      res_q   <= '0;
      flags_q <= '0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (accept) begin
      if (is_mul) begin
        state  <= S_MUL;
        mcand  <= {{WIDTH{1'b0}}, bus.data1};
        mplier <= bus.data2;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        state   <= S_DONE;
        res_q   <= r_c;
        flags_q <= {(r_c == '0), r_c[WIDTH-1], c_c, v_c};
      end
    end else if (state == S_MUL) begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST_ITER) begin
        state   <= S_DONE;
        res_q   <= acc_n[WIDTH-1:0];
        flags_q <= {(acc_n[WIDTH-1:0] == '0), acc_n[WIDTH-1],
                    (|acc_n[2*WIDTH-1:WIDTH]), 1'b0};
      end
    end else if (state == S_DONE) begin
      if (bus.out_ready) state <= S_IDLE;
    end else begin
      // IDLE with nothing accepted, or an unused encoding.
      state <= S_IDLE;
    end
  end
endmodule
